// File: rtl/patch_pkg.sv
// Shared definitions for the crossfading patch matrix.
//   state_t      sequencer states (IDLE / RUN / COMMIT)
//   sel_width    width of a source select (0 = silence, 1..n_in = sources)
//   idx_width    width of a destination index (never below 1)
//   w_old_of     weight of the outgoing source for a given fade position
package patch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Fade exponent tops out at 10, so 11 bits always hold 2^K.
   localparam int KW_MAX = 11;

   function automatic int sel_width(input int n_in);
      return $clog2(n_in + 1);
   endfunction

   function automatic int idx_width(input int n_out);
      return (n_out > 1) ? $clog2(n_out) : 1;
   endfunction

   function automatic logic [KW_MAX-1:0] w_old_of(input logic [KW_MAX-1:0] k,
                                                   input int               k_log2);
      return (KW_MAX'(1) << k_log2) - k;
   endfunction

endpackage

// File: rtl/xfade_mac.sv
// Two-phase signed multiply-accumulate shared by all destinations.
//   clk, rst_n  clock, async active-low reset
//   en          advance the accumulator this cycle
//   phase_b     0: acc = sample*weight, 1: acc += sample*weight
//   sample      signed source sample
//   weight      unsigned fade weight (0..2^SHIFT)
//   result      (acc + sample*weight) >>> SHIFT, valid during phase B
module xfade_mac #(
   parameter int BITSIZE = 16,
   parameter int WW      = 7,
   parameter int SHIFT   = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      phase_b,
   input  logic signed [BITSIZE-1:0] sample,
   input  logic        [WW-1:0]      weight,
   output logic signed [BITSIZE-1:0] result
);

   // BITSIZE + SHIFT + 2 bits: the weights of one pair sum to 2^SHIFT.
   localparam int AW = BITSIZE + WW + 1;

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] prod;
   logic signed [AW-1:0] sum;

   assign prod   = AW'(sample) * AW'($signed({1'b0, weight}));
   assign sum    = (phase_b ? acc : '0) + prod;
   assign result = BITSIZE'(sum >>> SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  acc <= '0;
      else if (en) acc <= sum;
   end

endmodule

// File: rtl/patch_matrix_xfade.sv
// N_IN x N_OUT audio routing matrix with per-destination linear crossfade.
//   clk, rst_n   system clock, async active-low reset
//   lrclk        codec LR clock (async), rising edge starts a sample
//   in_flat      packed signed sources
//   xfade_en     1: fade on re-patch, 0: hard switch at next commit
//   cfg_*        valid/ready write of a destination's source select
//   out_flat     packed registered destinations
//   out_valid    one-cycle pulse when out_flat updates
//   overrun      sticky: strobe arrived while a sample was in progress
//
// state  | meaning
// IDLE   | waiting for a synchronised lrclk rising edge
// RUN    | two MAC cycles per destination into the shadow buffer
// COMMIT | publish shadow, advance fades, apply pending selects
module patch_matrix_xfade
   import patch_pkg::*;
#(
   parameter int BITSIZE    = 16,
   parameter int N_IN       = 10,
   parameter int N_OUT      = 11,
   parameter int XFADE_LOG2 = 6,
   parameter int SELW       = sel_width(N_IN),
   parameter int OW         = idx_width(N_OUT)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     lrclk,
   input  logic [N_IN*BITSIZE-1:0]  in_flat,
   input  logic                     xfade_en,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [OW-1:0]            cfg_out,
   input  logic [SELW-1:0]          cfg_sel,
   output logic [N_OUT*BITSIZE-1:0] out_flat,
   output logic                     out_valid,
   output logic                     overrun
);

   localparam int            WW     = XFADE_LOG2 + 1;
   localparam logic [WW-1:0] K_FULL = {1'b1, {XFADE_LOG2{1'b0}}};

   state_t                     state, state_nx;
   logic [2:0]                 lr_sync;
   logic                       strobe;
   logic                       alive;
   logic [OW-1:0]              j;
   logic                       phase_b;
   logic [N_IN*BITSIZE-1:0]    in_reg;
   logic [N_OUT*BITSIZE-1:0]   shadow;

   logic [SELW-1:0]            cur_sel    [N_OUT];
   logic [SELW-1:0]            new_sel    [N_OUT];
   logic [SELW-1:0]            pend_sel   [N_OUT];
   logic                       pend_valid [N_OUT];
   logic                       fading     [N_OUT];
   logic [WW-1:0]              k          [N_OUT];
   logic [WW-1:0]              k_inc      [N_OUT];
   logic                       fade_done  [N_OUT];
   logic [SELW-1:0]            base_sel   [N_OUT];

   logic signed [BITSIZE-1:0]  mac_sample;
   logic [WW-1:0]              mac_weight;
   logic signed [BITSIZE-1:0]  mac_result;
   logic                       cfg_hit;
   logic [SELW-1:0]            cfg_sel_c;

   function automatic logic signed [BITSIZE-1:0] pick(input logic [SELW-1:0]         sel,
                                                      input logic [N_IN*BITSIZE-1:0] flat);
      logic signed [BITSIZE-1:0] v;
      v = '0;
      for (int i = 0; i < N_IN; i++)
         if (int'(sel) == i + 1) v = flat[i*BITSIZE +: BITSIZE];
      return v;
   endfunction

   assign strobe    = lr_sync[1] & ~lr_sync[2];
   assign cfg_ready = alive && (state != ST_COMMIT);
   assign cfg_hit   = cfg_valid && cfg_ready && (int'(cfg_out) < N_OUT);
   assign cfg_sel_c = (int'(cfg_sel) > N_IN) ? '0 : cfg_sel;

   always_comb begin
      mac_sample = phase_b ? pick(new_sel[j], in_reg) : pick(cur_sel[j], in_reg);
      mac_weight = phase_b ? k[j] : WW'(w_old_of(KW_MAX'(k[j]), XFADE_LOG2));
   end

   // The source a destination rests on once this commit's fade step is done.
   always_comb begin
      for (int d = 0; d < N_OUT; d++) begin
         k_inc[d]     = k[d] + 1'b1;
         fade_done[d] = fading[d] && (k_inc[d] == K_FULL);
         base_sel[d]  = fade_done[d] ? new_sel[d] : cur_sel[d];
      end
   end

   xfade_mac #(
      .BITSIZE (BITSIZE),
      .WW      (WW),
      .SHIFT   (XFADE_LOG2)
   ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (state == ST_RUN),
      .phase_b (phase_b),
      .sample  (mac_sample),
      .weight  (mac_weight),
      .result  (mac_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (strobe) state_nx = ST_RUN;
         ST_RUN:    if (phase_b && (j == OW'(N_OUT - 1))) state_nx = ST_COMMIT;
         ST_COMMIT: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lr_sync   <= '0;
         alive     <= 1'b0;
         j         <= '0;
         phase_b   <= 1'b0;
         in_reg    <= '0;
         shadow    <= '0;
         out_flat  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         lr_sync   <= {lr_sync[1:0], lrclk};
         alive     <= 1'b1;
         out_valid <= 1'b0;
         if (strobe && (state != ST_IDLE)) overrun <= 1'b1;
         case (state)
            ST_IDLE: begin
               j       <= '0;
               phase_b <= 1'b0;
               if (strobe) in_reg <= in_flat;
            end
            ST_RUN: begin
               phase_b <= ~phase_b;
               if (phase_b) begin
                  shadow[j*BITSIZE +: BITSIZE] <= mac_result;
                  j <= j + 1'b1;
               end
            end
            ST_COMMIT: begin
               out_flat  <= shadow;
               out_valid <= 1'b1;
               j         <= '0;
               phase_b   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < N_OUT; d++) begin
            cur_sel[d]    <= '0;
            new_sel[d]    <= '0;
            pend_sel[d]   <= '0;
            pend_valid[d] <= 1'b0;
            fading[d]     <= 1'b0;
            k[d]          <= '0;
         end
      end else begin
         for (int d = 0; d < N_OUT; d++) begin
            if (state == ST_COMMIT) begin
               if (!xfade_en && pend_valid[d]) begin
                  // Hard switch, also aborts any fade in progress.
                  cur_sel[d]    <= pend_sel[d];
                  new_sel[d]    <= pend_sel[d];
                  fading[d]     <= 1'b0;
                  k[d]          <= '0;
                  pend_valid[d] <= 1'b0;
               end else if (!fading[d] || fade_done[d]) begin
                  cur_sel[d] <= base_sel[d];
                  fading[d]  <= 1'b0;
                  k[d]       <= '0;
                  if (pend_valid[d]) begin
                     pend_valid[d] <= 1'b0;
                     if (pend_sel[d] != base_sel[d]) begin
                        new_sel[d] <= pend_sel[d];
                        fading[d]  <= 1'b1;
                     end
                  end
               end else begin
                  k[d] <= k_inc[d];
               end
            end else if (cfg_hit && (cfg_out == OW'(d))) begin
               pend_sel[d]   <= cfg_sel_c;
               pend_valid[d] <= 1'b1;
            end
         end
      end
   end

endmodule
